// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared defaults and helpers for async_fifo and its read-side drain
// Contents: BITS default word width, word_t, clog2_depth() for pointer/level sizing.
package async_fifo_pkg;

   localparam int BITS = 32;

   typedef logic [BITS-1:0] word_t;

   // Elaboration-time ceil(log2(depth)); callers guarantee depth >= 2.
   function automatic int clog2_depth(input int depth);
      int r;
      r = 0;
      while ((1 << r) < depth) r++;
      return r;
   endfunction

endpackage

// File: rtl/drain_buf.sv
// rtl/drain_buf.sv - DEPTH-entry register FIFO holding words returned by the async_fifo
// Ports: clk, rst_n (sync, active-low); push/push_data write the tail;
//        pop advances the head; head_data is the head entry; level is occupancy 0..DEPTH.
module drain_buf
   import async_fifo_pkg::clog2_depth;
#(
   parameter int BITS  = 32,
   parameter int DEPTH = 2,
   localparam int PTR_W = clog2_depth(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [BITS-1:0]  push_data,
   input  logic             pop,
   output logic [BITS-1:0]  head_data,
   output logic [LVL_W-1:0] level
);

   logic [BITS-1:0]  mem_q [DEPTH];
   logic [BITS-1:0]  mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             do_pop;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      // A pop on an empty buffer is ignored so the pointers never cross.
      do_pop   = pop && (level_q != '0);

      // Pointers are PTR_W bits wide and DEPTH is a power of two, so
      // the increments wrap modulo DEPTH on their own.
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      if (push && !do_pop) begin
         level_d = level_q + 1'b1;
      end else if (!push && do_pop) begin
         level_d = level_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         // The issue logic reserves a slot for every read, so a word can
         // never arrive while the buffer is already full.
         assert (!(push && (level_q == LVL_W'(DEPTH))));
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign level     = level_q;

endmodule

// File: rtl/fifo_read_drain.sv
// rtl/fifo_read_drain.sv - drains the async_fifo read port into a valid/ready stream
// Ports: clk (FIFO read clock), rst_n (sync, active-low);
//        FIFO side: p_fifo_empty, p_fifo_read_en, p_fifo_read_data (1-cycle read latency);
//        stream side: p_out_valid, p_out_ready, p_out_data;
//        status: p_level (local buffer occupancy), p_word_count (words delivered, wrapping).
module fifo_read_drain
   import async_fifo_pkg::clog2_depth;
#(
   parameter int BITS     = 32,
   parameter int DEPTH    = 2,
   parameter int CNT_BITS = 32,
   localparam int LVL_W   = clog2_depth(DEPTH) + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                p_fifo_empty,
   output logic                p_fifo_read_en,
   input  logic [BITS-1:0]     p_fifo_read_data,
   output logic                p_out_valid,
   input  logic                p_out_ready,
   output logic [BITS-1:0]     p_out_data,
   output logic [LVL_W-1:0]    p_level,
   output logic [CNT_BITS-1:0] p_word_count
);

   localparam int DW = LVL_W + 1;

   logic                inflight_q, inflight_d;
   logic [CNT_BITS-1:0] count_q, count_d;
   logic [LVL_W-1:0]    level;
   logic [DW-1:0]       demand;
   logic                pop;
   logic                read_en;

   drain_buf #(
      .BITS  (BITS),
      .DEPTH (DEPTH)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight_q),
      .push_data (p_fifo_read_data),
      .pop       (pop),
      .head_data (p_out_data),
      .level     (level)
   );

   assign p_out_valid = (level != '0);

   always_comb begin
      pop        = p_out_valid && p_out_ready;
      // Slots committed next cycle: stored words plus the word in flight,
      // less the one leaving now. Crediting the same-cycle pop is what lets
      // a 2-entry buffer sustain one word per cycle.
      demand     = {1'b0, level} + DW'(inflight_q) - DW'(pop);
      read_en    = rst_n && !p_fifo_empty && (demand < DW'(DEPTH));
      inflight_d = read_en;
      count_d    = count_q + CNT_BITS'(pop);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // Clearing inflight drops a word returning just after reset.
         inflight_q <= 1'b0;
         count_q    <= '0;
      end else begin
         assert (!(read_en && p_fifo_empty));
         inflight_q <= inflight_d;
         count_q    <= count_d;
      end
   end

   assign p_fifo_read_en = read_en;
   assign p_level        = level;
   assign p_word_count   = count_q;

endmodule

// File: tb/tb_fifo_read_drain.sv
// tb/tb_fifo_read_drain.sv - self-checking bench for fifo_read_drain with a queue-based FIFO model
module tb_fifo_read_drain;

   localparam int BITS     = 32;
   localparam int DEPTH    = 2;
   localparam int CNT_BITS = 32;
   localparam int LVL_W    = $clog2(DEPTH) + 1;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                p_fifo_empty;
   logic                p_fifo_read_en;
   logic [BITS-1:0]     p_fifo_read_data;
   logic                p_out_valid;
   logic                p_out_ready;
   logic [BITS-1:0]     p_out_data;
   logic [LVL_W-1:0]    p_level;
   logic [CNT_BITS-1:0] p_word_count;

   always #5 clk = ~clk;

   fifo_read_drain #(
      .BITS     (BITS),
      .DEPTH    (DEPTH),
      .CNT_BITS (CNT_BITS)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .p_fifo_empty     (p_fifo_empty),
      .p_fifo_read_en   (p_fifo_read_en),
      .p_fifo_read_data (p_fifo_read_data),
      .p_out_valid      (p_out_valid),
      .p_out_ready      (p_out_ready),
      .p_out_data       (p_out_data),
      .p_level          (p_level),
      .p_word_count     (p_word_count)
   );

   typedef struct {
      bit          ready;
      bit          ren;
      bit          valid;
      int          level;
      logic [31:0] data;
   } vec_t;

   vec_t        tbl [13];
   int          checks = 0;
   int          passed = 0;
   logic [31:0] src_q [$];
   logic [31:0] sb_q  [$];
   logic [31:0] got_q [$];
   bit          avail;
   bit          model_on;
   bit          issued_prev;
   int          captured_total;
   int          popped_total;
   bit          last_ren, last_valid, last_issued;
   int          last_level;
   logic [31:0] last_data;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
   endtask

   task automatic update_empty();
      p_fifo_empty = !(avail && (src_q.size() != 0));
   endtask

   task automatic preload16();
      src_q.delete();
      for (int i = 1; i <= 16; i++) src_q.push_back(32'(i));
      update_empty();
   endtask

   task automatic apply_reset(input int n, input bit check);
      rst_n    = 1'b0;
      model_on = 1'b0;
      repeat (n) begin
         @(negedge clk);
         if (check) begin
            chk("rst_read_en", p_fifo_read_en, 0);
            chk("rst_valid", p_out_valid, 0);
            chk("rst_level", p_level, 0);
            chk("rst_count", p_word_count, 0);
            chk("rst_data", p_out_data, 0);
         end
         @(posedge clk);
         #1;
      end
      rst_n          = 1'b1;
      issued_prev    = 1'b0;
      captured_total = 0;
      popped_total   = 0;
      sb_q.delete();
      got_q.delete();
      model_on       = 1'b1;
   endtask

   // One clock cycle: sample at the falling edge, compare against the
   // occupancy model (words returned minus words taken) and the in-order
   // scoreboard, then advance the FIFO model after the rising edge.
   task automatic step();
      bit          issued, popped, mvalid, eren;
      int          mlevel;
      logic [31:0] w;
      w = '0;
      @(negedge clk);
      mlevel      = captured_total - popped_total;
      mvalid      = (mlevel != 0);
      issued      = p_fifo_read_en && !p_fifo_empty;
      popped      = p_out_valid && p_out_ready;
      last_ren    = p_fifo_read_en;
      last_valid  = p_out_valid;
      last_issued = issued;
      last_level  = int'(p_level);
      last_data   = p_out_data;
      chk("read_while_empty", p_fifo_read_en & p_fifo_empty, 0);
      if (model_on) begin
         eren = !p_fifo_empty &&
                ((mlevel + int'(issued_prev) - int'(mvalid && p_out_ready)) < DEPTH);
         chk("level", p_level, mlevel);
         chk("valid", p_out_valid, mvalid);
         chk("read_en", p_fifo_read_en, eren);
         chk("count", p_word_count, popped_total);
         if (popped) begin
            got_q.push_back(p_out_data);
            if (sb_q.size() == 0) begin
               checks++;
               $display("FAIL extra_word: actual=%0h required=none", p_out_data);
            end else begin
               chk("data", p_out_data, sb_q.pop_front());
            end
         end
      end
      if (issued) begin
         w = src_q.pop_front();
         sb_q.push_back(w);
      end
      @(posedge clk);
      #1;
      captured_total += int'(issued_prev);
      popped_total   += int'(popped);
      issued_prev     = issued;
      if (issued) p_fifo_read_data = w;
      update_empty();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int reads_bp, gap_reads, writes, cyc;

      // Backpressure trace from reset release: {ready, read_en, valid, level, data}
      tbl[0]  = '{1'b0, 1'b1, 1'b0, 0, 32'h0};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 0, 32'h0};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 1, 32'h1};
      for (int i = 3; i <= 9; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 2, 32'h1};
      tbl[10] = '{1'b1, 1'b1, 1'b1, 2, 32'h1};
      tbl[11] = '{1'b1, 1'b1, 1'b1, 1, 32'h2};
      tbl[12] = '{1'b1, 1'b1, 1'b1, 1, 32'h3};

      rst_n            = 1'b0;
      p_out_ready      = 1'b0;
      p_fifo_read_data = '0;
      avail            = 1'b1;
      model_on         = 1'b0;
      issued_prev      = 1'b0;
      captured_total   = 0;
      popped_total     = 0;
      preload16();

      // Reset hold with a non-empty FIFO
      apply_reset(3, 1'b1);

      // Streaming at full rate
      p_out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         step();
         chk("stream_valid", last_valid, (c >= 2 && c <= 17));
         if (c >= 2 && c <= 17) chk("stream_data", last_data, c - 1);
      end
      chk("stream_count", p_word_count, 16);

      // Backpressure
      preload16();
      apply_reset(1, 1'b0);
      reads_bp = 0;
      for (int c = 0; c < 13; c++) begin
         p_out_ready = tbl[c].ready;
         step();
         if (c < 10) reads_bp += int'(last_issued);
         chk("bp_read_en", last_ren, tbl[c].ren);
         chk("bp_valid", last_valid, tbl[c].valid);
         chk("bp_level", last_level, tbl[c].level);
         chk("bp_data", last_data, tbl[c].data);
      end
      chk("bp_reads_stalled", reads_bp, 2);
      p_out_ready = 1'b1;
      for (int i = 0; i < 40 && popped_total < 16; i++) step();
      chk("bp_delivered", popped_total, 16);
      chk("bp_count", p_word_count, 16);

      // Empty gap between two words
      src_q.delete();
      update_empty();
      apply_reset(1, 1'b0);
      p_out_ready = 1'b1;
      src_q.push_back(32'hA);
      update_empty();
      step();
      chk("gap_first_read", last_issued, 1);
      gap_reads = 0;
      repeat (5) begin
         step();
         gap_reads += int'(last_ren);
      end
      chk("gap_no_reads", gap_reads, 0);
      src_q.push_back(32'hB);
      update_empty();
      repeat (6) step();
      chk("gap_words", got_q.size(), 2);
      if (got_q.size() == 2) begin
         chk("gap_word0", got_q[0], 32'hA);
         chk("gap_word1", got_q[1], 32'hB);
      end

      // Random ready against a bounded 16-entry FIFO with bursty writer
      src_q.delete();
      update_empty();
      apply_reset(1, 1'b0);
      void'($urandom(7));
      writes = 0;
      cyc    = 0;
      while (popped_total < 1000 && cyc < 20000) begin
         p_out_ready = 1'($urandom_range(0, 1));
         step();
         if (writes < 1000 && src_q.size() < 16 && $urandom_range(0, 3) != 0) begin
            src_q.push_back($urandom);
            writes++;
         end
         update_empty();
         cyc++;
      end
      chk("rand_in_budget", (cyc < 20000), 1);
      chk("rand_count", p_word_count, 1000);
      chk("rand_sb_empty", sb_q.size(), 0);

      // Reset the cycle after a read issue
      preload16();
      apply_reset(1, 1'b0);
      p_out_ready = 1'b1;
      repeat (5) step();
      chk("mid_issue", last_issued, 1);
      chk("mid_count_pre", p_word_count, 3);
      model_on = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      chk("mid_rst_read_en", p_fifo_read_en, 0);
      @(posedge clk);
      #1;
      chk("mid_level", p_level, 0);
      chk("mid_count", p_word_count, 0);
      chk("mid_valid", p_out_valid, 0);
      avail = 1'b0;
      update_empty();
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_discard_level", p_level, 0);
      chk("mid_discard_valid", p_out_valid, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
